// File: rtl/reg_ring_pkg.sv
// reg_ring_pkg: shared state type, widths and constants for the register ring initiator
package reg_ring_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int DEF_ADDR_WIDTH = 23;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SRC_WIDTH = 2;
  localparam int TIMER_WIDTH = 10;
endpackage

// File: rtl/reg_ring_slice.sv
// reg_ring_slice: one registered ring stage carrying either forwarded or locally issued fields
module reg_ring_slice #(
  parameter int RW = 60
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          sel_fwd_i,
  input  logic [RW-1:0] fwd_i,
  input  logic [RW-1:0] loc_i,
  output logic [RW-1:0] ring_o
);
  logic [RW-1:0] ring_q, ring_d;
  // an unloaded stage drives an idle (all-zero) ring cycle
  always_comb ring_d = load_i ? (sel_fwd_i ? fwd_i : loc_i) : '0;
  // stage register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ring_q <= '0;
    else ring_q <= ring_d;
  assign ring_o = ring_q;
endmodule

// File: rtl/reg_ring_initiator.sv
// reg_ring_initiator: master end of the register ring, one outstanding command at a time
module reg_ring_initiator
  import reg_ring_pkg::*;
#(
  parameter int                   ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                   DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                   SRC_WIDTH  = DEF_SRC_WIDTH,
  parameter logic [SRC_WIDTH-1:0] SRC_ID     = SRC_WIDTH'(1),
  parameter int                   TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_rdy,
  input  logic                  cmd_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  input  logic                  reg_req_in,
  input  logic                  reg_ack_in,
  input  logic                  reg_rd_wr_L_in,
  input  logic [ADDR_WIDTH-1:0] reg_addr_in,
  input  logic [DATA_WIDTH-1:0] reg_data_in,
  input  logic [SRC_WIDTH-1:0]  reg_src_in,
  output logic                  reg_req_out,
  output logic                  reg_ack_out,
  output logic                  reg_rd_wr_L_out,
  output logic [ADDR_WIDTH-1:0] reg_addr_out,
  output logic [DATA_WIDTH-1:0] reg_data_out,
  output logic [SRC_WIDTH-1:0]  reg_src_out
);
  localparam int RW = 3 + ADDR_WIDTH + DATA_WIDTH + SRC_WIDTH;
  state_e                 state_q, state_d;
  logic                   rd_wr_q, rd_wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d, rsp_to_q, rsp_to_d;
  logic                   fwd, own, launch;
  logic [RW-1:0]          ring;
  assign fwd = reg_req_in && reg_src_in != SRC_ID;
  assign own = reg_req_in && reg_src_in == SRC_ID;
  // any incoming request (foreign or stray own tag) occupies the next output cycle
  assign launch = state_q == ISSUE && !reg_req_in;
  assign cmd_rdy = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign rsp_timeout = rsp_to_q;
  // command latch, launch, return matching and timeout
  always_comb begin
    state_d = state_q;
    rd_wr_d = rd_wr_q;
    addr_d = addr_q;
    data_d = data_q;
    timer_d = timer_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    rsp_to_d = rsp_to_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = ISSUE;
        rd_wr_d = cmd_rd_wr_L;
        addr_d = cmd_addr;
        data_d = cmd_data;
      end
      ISSUE: if (launch) begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: if (own) begin
        state_d = RESP;
        rsp_data_d = reg_data_in;
        rsp_err_d = !reg_ack_in;
        rsp_to_d = 1'b0;
      end else if (timer_q == TIMER_WIDTH'(TIMEOUT)) begin
        state_d = RESP;
        rsp_data_d = DATA_WIDTH'(TIMEOUT_DATA);
        rsp_err_d = 1'b0;
        rsp_to_d = 1'b1;
      end else timer_d = timer_q + 1'b1;
      RESP: if (rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and response registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      rd_wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      timer_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_wr_q <= rd_wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      timer_q <= timer_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      rsp_to_q <= rsp_to_d;
    end
  reg_ring_slice #(.RW(RW)) u_out (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (fwd || launch),
    .sel_fwd_i(fwd),
    .fwd_i    ({reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in}),
    .loc_i    ({1'b1, 1'b0, rd_wr_q, addr_q, data_q, SRC_ID}),
    .ring_o   (ring)
  );
  assign {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out} = ring;
endmodule

// File: tb/tb_reg_ring_initiator.sv
// tb_reg_ring_initiator: randomized ring traffic checked every cycle against a transaction-level model
module tb_reg_ring_initiator;
  localparam int AW = 23, DW = 32, SW = 2, TO = 8;
  localparam logic [SW-1:0] MY = 2'd1;
  typedef struct packed {
    logic req; logic ack; logic rw; logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] src;
  } ring_t;
  logic clk = 0, reset = 0;
  logic cmd_valid = 0, cmd_rd_wr_L = 0, rsp_rdy = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic cmd_rdy, rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_data;
  logic ro_req, ro_ack, ro_rw;
  logic [AW-1:0] ro_addr;
  logic [DW-1:0] ro_data;
  logic [SW-1:0] ro_src;
  ring_t ri = '0;
  ring_t ro;
  assign ro = {ro_req, ro_ack, ro_rw, ro_addr, ro_data, ro_src};
  always #5 clk = ~clk;
  reg_ring_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_WIDTH(SW), .SRC_ID(MY), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy), .cmd_rd_wr_L(cmd_rd_wr_L), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .reg_req_in(ri.req), .reg_ack_in(ri.ack), .reg_rd_wr_L_in(ri.rw), .reg_addr_in(ri.addr),
    .reg_data_in(ri.data), .reg_src_in(ri.src),
    .reg_req_out(ro_req), .reg_ack_out(ro_ack), .reg_rd_wr_L_out(ro_rw), .reg_addr_out(ro_addr),
    .reg_data_out(ro_data), .reg_src_out(ro_src)
  );

  int vectors = 0, miscompares = 0;
  // transaction-level model: one command in flight, launched on the first free output cycle
  ring_t e_ring = '0, cmd_m = '0;
  bit busy = 0, launched = 0, has_rsp = 0;
  int edge_n = 0, launch_edge = 0;
  logic [DW-1:0] e_data = '0;
  logic e_err = 0, e_to = 0;
  // ring responder behaviour
  bit ret_pend = 0, dat_fix = 0;
  int ret_at = 0, dly_cfg = -1, ack_cfg = -1, p_fwd = 0;
  ring_t ret_tr = '0;
  logic [DW-1:0] dat_val = '0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic model_edge();
    bit waiting, fire;
    edge_n++;
    if (!reset) begin
      busy = 0; launched = 0; has_rsp = 0; e_ring = '0; e_data = '0; e_err = 0; e_to = 0;
      return;
    end
    waiting = busy && launched && !has_rsp;
    fire = busy && !launched && !ri.req;
    e_ring = (ri.req && ri.src != MY) ? ri : fire ? cmd_m : '0;
    if (fire) begin launched = 1; launch_edge = edge_n; end
    if (waiting && ri.req && ri.src == MY) begin
      has_rsp = 1; e_data = ri.data; e_err = !ri.ack; e_to = 0;
    end else if (waiting && edge_n - launch_edge == TO + 1) begin
      has_rsp = 1; e_data = 32'hDEADBEEF; e_err = 0; e_to = 1;
    end else if (has_rsp && rsp_rdy) begin
      busy = 0; has_rsp = 0; launched = 0;
    end else if (!busy && cmd_valid) begin
      busy = 1; cmd_m = {1'b1, 1'b0, cmd_rd_wr_L, cmd_addr, cmd_data, MY};
    end
  endtask

  task automatic compare();
    chk("ring_out", 64'(ro), 64'(e_ring));
    chk("cmd_rdy", 64'(cmd_rdy), 64'(!busy));
    chk("rsp_valid", 64'(rsp_valid), 64'(has_rsp));
    chk("rsp_fields", {30'd0, rsp_data, rsp_err, rsp_timeout}, {30'd0, e_data, e_err, e_to});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive();
    logic [SW-1:0] s;
    if (e_ring.req && e_ring.src == MY && !ret_pend && dly_cfg != -2) begin
      ret_pend = 1;
      ret_at = edge_n + (dly_cfg < 0 ? int'($urandom_range(0, 11)) : dly_cfg);
      ret_tr = e_ring;
      ret_tr.ack = ack_cfg < 0 ? ($urandom_range(0, 3) != 0) : ack_cfg[0];
      ret_tr.data = dat_fix ? dat_val : (e_ring.rw ? DW'($urandom) : e_ring.data);
    end
    ri = '0;
    if (ret_pend && edge_n >= ret_at) begin
      ri = ret_tr;
      ret_pend = 0;
    end else if (int'($urandom_range(0, 99)) < p_fwd) begin
      do s = SW'($urandom); while (s == MY);
      ri = {1'b1, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), s};
    end
  endtask

  task automatic cyc();
    drive();
    tick();
  endtask

  task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1; cmd_rd_wr_L = rw; cmd_addr = a; cmd_data = d;
    cyc();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(string n);
    for (int i = 0; i < 40 && !rsp_valid; i++) cyc();
    chk(n, 64'(rsp_valid), 64'd1);
  endtask

  task automatic take();
    rsp_rdy = 1;
    cyc();
    rsp_rdy = 0;
  endtask

  initial begin
    int n, launches;
    tick();
    tick();
    chk("reset_ring", 64'(ro), 64'd0);
    chk("reset_rsp", {30'd0, rsp_data, rsp_valid, rsp_err}, 64'd0);
    reset = 1;
    tick();
    chk("reset_rdy", 64'(cmd_rdy), 64'd1);
    // write through an acking loopback
    p_fwd = 0; dly_cfg = 0; ack_cfg = 1;
    issue(1'b0, 23'h000200, 32'h00000013);
    cyc();
    chk("wr_launch", 64'(ro), 64'({1'b1, 1'b0, 1'b0, 23'h000200, 32'h00000013, 2'd1}));
    wait_rsp("wr_rsp");
    chk("wr_status", {62'd0, rsp_err, rsp_timeout}, 64'd0);
    chk("wr_pulse", 64'(ro_req), 64'd0);
    take();
    // read with fixed data
    dat_fix = 1; dat_val = 32'hCAFEF00D; dly_cfg = 3;
    issue(1'b1, 23'h000310, 32'h0);
    wait_rsp("rd_rsp");
    chk("rd_data", {31'd0, rsp_err, rsp_data}, 64'h00000000CAFEF00D);
    take();
    // unclaimed address
    ack_cfg = 0; dat_val = 32'h0BADC0DE;
    issue(1'b1, 23'h7FFFF0, 32'h0);
    wait_rsp("unclaimed_rsp");
    chk("unclaimed", {30'd0, rsp_err, rsp_timeout, rsp_data}, {30'd0, 2'b10, 32'h0BADC0DE});
    take();
    // no return: timeout then late return dropped
    dly_cfg = -2;
    issue(1'b1, 23'h000010, 32'h0);
    cyc();
    chk("to_launch", 64'(ro_req), 64'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin cyc(); n++; end
    chk("to_latency", 64'(n), 64'd9);
    chk("to_fields", {30'd0, rsp_timeout, rsp_err, rsp_data}, {30'd0, 2'b10, 32'hDEADBEEF});
    take();
    ri = {1'b1, 1'b1, 1'b1, 23'h000010, 32'h55, MY};
    tick();
    ri = '0;
    chk("late_drop_ring", 64'(ro), 64'd0);
    tick();
    chk("late_drop_rsp", {62'd0, rsp_valid, cmd_rdy}, 64'd1);
    // foreign burst defers launch
    dly_cfg = 1; ack_cfg = 1; dat_fix = 0; p_fwd = 100;
    issue(1'b0, 23'h000044, 32'h0000A5A5);
    ri = {1'b1, 1'b0, 1'b1, 23'h012345, 32'h600DF00D, 2'd2};
    tick();
    chk("fwd_copy", 64'(ro), 64'({1'b1, 1'b0, 1'b1, 23'h012345, 32'h600DF00D, 2'd2}));
    launches = 0;
    repeat (6) begin cyc(); if (ro_req && ro_src == MY) launches++; end
    chk("fwd_defer", 64'(launches), 64'd0);
    p_fwd = 0;
    for (int i = 0; i < 30 && !rsp_valid; i++) begin cyc(); if (ro_req && ro_src == MY) launches++; end
    chk("fwd_single_launch", 64'(launches), 64'd1);
    take();
    // reset during WAIT
    dly_cfg = -2;
    issue(1'b0, 23'h000020, 32'h1);
    cyc(); cyc(); cyc();
    reset = 0;
    #1;
    chk("rst_async_ring", 64'(ro), 64'd0);
    chk("rst_async_rsp", {30'd0, rsp_data, rsp_valid, rsp_err}, 64'd0);
    ret_pend = 0;
    tick();
    reset = 1;
    tick();
    chk("rst_rdy", 64'(cmd_rdy), 64'd1);
    ri = {1'b1, 1'b1, 1'b0, 23'h000020, 32'h77, MY};
    tick();
    ri = '0;
    chk("rst_stray_ring", 64'(ro), 64'd0);
    repeat (12) cyc();
    chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
    // randomized traffic
    dly_cfg = -1; ack_cfg = -1;
    for (int b = 0; b < 40; b++) begin
      p_fwd = int'($urandom_range(0, 60));
      for (int i = 0; i < 50; i++) begin
        cmd_valid = 1'($urandom); cmd_rd_wr_L = 1'($urandom);
        cmd_addr = AW'($urandom); cmd_data = $urandom;
        rsp_rdy = $urandom_range(0, 2) != 0;
        cyc();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/reg_ring_initiator.md
# reg_ring_initiator

Master end of the UDP register ring. It accepts single read/write commands from a local controller, such as a program loader writing Address/Instruction software registers into the pipeline datapath. For each command it launches one ring transaction, matches the returning transaction by source ID, and hands back the read data or a status flag. It sits at the head of the register chain: its ring outputs feed the first responder block, and the last block's outputs return to its ring inputs.

## Interface
Parameters:
- ADDR_WIDTH, 23: ring address width (equals UDP_REG_ADDR_WIDTH).
- DATA_WIDTH, 32: ring data width (equals CPCI_NF2_DATA_WIDTH).
- SRC_WIDTH, 2: ring source-tag width.
- SRC_ID, 2'd1: this initiator's tag; returns carrying it are consumed.
- TIMEOUT, 255: cycles to wait for a return before failing; range 1..1023.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: sole clock.
  - reset, in, 1: asynchronous, active-low.
- Command side:
  - cmd_valid, in, 1: command offered.
  - cmd_rdy, out, 1: command accepted when cmd_valid && cmd_rdy.
  - cmd_rd_wr_L, in, 1: 1 = read, 0 = write.
  - cmd_addr, in, ADDR_WIDTH: register address.
  - cmd_data, in, DATA_WIDTH: write data; ignored for reads.
- Response side:
  - rsp_valid, out, 1: response held until taken.
  - rsp_rdy, in, 1: response consumed when rsp_valid && rsp_rdy.
  - rsp_data, out, DATA_WIDTH: returned ring data.
  - rsp_err, out, 1: returned with ack = 0 (no block claimed the address).
  - rsp_timeout, out, 1: no return within TIMEOUT cycles.
- Ring inputs: reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in; in; 1/1/1/ADDR/DATA/SRC.
- Ring outputs: reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out; out; same widths; all registered.

## Operation
- States:
  - IDLE: cmd_rdy = 1. On accept, latch the command and go to ISSUE.
  - ISSUE: drive one ring cycle with req = 1, ack = 0, src = SRC_ID and the latched rd_wr_L/addr/data. Clear the timer and go to WAIT.
  - WAIT: the timer increments each cycle. The first reg_req_in with reg_src_in == SRC_ID is captured: rsp_data = reg_data_in, rsp_err = !reg_ack_in, rsp_timeout = 0. Go to RESP.
  - WAIT timeout: when the timer reaches TIMEOUT, set rsp_data = 32'hDEAD_BEEF, rsp_err = 0, rsp_timeout = 1, and go to RESP.
  - RESP: rsp_valid = 1 with fields stable. On rsp_rdy go to IDLE.
- cmd_rdy is 0 in every state except IDLE. Exactly one transaction is outstanding at a time.
- Forwarding:
  - Any reg_req_in whose src != SRC_ID is copied, all six fields, to the ring outputs one cycle later, in every state.
  - Forwarding has priority over ISSUE. On a collision the FSM stays in ISSUE and launches on the next free output cycle.
- Own-tag returns are never forwarded. The ring outputs are idle in the following cycle.
- A stray own-tag return arriving outside WAIT (late after a timeout, or after reset) is dropped silently.
- Write response: rsp_data carries whatever the ring returned. The consumer ignores it.
- An idle ring output drives req = 0 and all other ring outputs 0.

## Timing
- Reset values: reg_*_out all 0; rsp_valid, rsp_err and rsp_timeout 0; rsp_data 0. cmd_rdy is 1 one cycle after reset deassertion, state IDLE.
- Reset mid-transaction: the outstanding command is abandoned, no response is produced, and a later return is dropped.
- Issue latency: command accepted at edge T gives reg_req_out = 1 during cycle T+1, or T+2 if a forward occupies T+1.
- reg_req_out is high for exactly one cycle per launch.
- Response latency: own return sampled at edge N gives rsp_valid = 1 from cycle N+1.
- Timeout: rsp_valid rises exactly TIMEOUT+1 cycles after the launch cycle when no own return arrives.
- Own return and timeout on the same edge: the return wins.
- Forward latency is exactly 1 cycle; throughput is one forward per cycle.
- Back-to-back commands: the next cmd_rdy rises in the cycle after rsp_valid && rsp_rdy. Minimum command-to-command spacing is 4 cycles with a 0-latency ring.

## Structure
- Package reg_ring_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the TIMEOUT_DATA constant 32'hDEAD_BEEF;
  - the default widths 23/32/2.
- Sub-module reg_ring_slice: a single registered six-field ring stage with a load enable and a select between forwarded and locally issued fields. It is instantiated once for the ring outputs.
- Timer width is 10 bits.

## Test plan
- Write accepted: cmd write addr 0x000200, data 0x00000013, through a loopback responder that sets ack.
  - reg_req_out pulses once with src = 1 and rd_wr_L = 0.
  - rsp_valid appears with rsp_err = 0 and rsp_timeout = 0.
- Read: responder returns data 0xCAFEF00D with ack = 1 → rsp_data = 0xCAFEF00D, rsp_err = 0.
- Unclaimed address: ring returns own tag with ack = 0 → rsp_err = 1, rsp_data equals the returned data.
- No return, TIMEOUT = 8 → rsp_timeout = 1 and rsp_data = 0xDEADBEEF exactly 9 cycles after launch. A late own return afterwards is dropped and the ring outputs stay idle.
- Foreign traffic: src = 2 transactions injected every cycle while a command is pending.
  - Each is forwarded unchanged with 1-cycle latency.
  - The launch is deferred until the first gap and then occurs exactly once.
- reset low during WAIT, then high:
  - All outputs return to 0 and no rsp_valid is produced.
  - cmd_rdy = 1 after release.
  - An own return arriving afterwards is dropped.
